// File: rtl/sc_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sc_io_pkg
//  Description : Shared segment constants, digit decode table and the
//                conversion state encoding for the HEX output port.
//  Revision    : 1.0 - initial release
// ============================================================================
package sc_io_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Active-low gfedcba; non-decimal codes go dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_bcd7seg.sv
`default_nettype none
// ============================================================================
//  Module      : sc_bcd7seg
//  Description : Combinational single-digit BCD to active-low 7-segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_bcd7seg
    import sc_io_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    assign o_seg = bcd_to_seg(i_bcd);

endmodule
`default_nettype wire

// File: rtl/sc_out_port_hex_display.sv
`default_nettype none
// ============================================================================
//  Module      : sc_out_port_hex_display
//  Description : Sequential double-dabble of an output-port word to decimal,
//                with an atomically committed 7-segment display image.
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_out_port_hex_display
    import sc_io_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5,
    parameter bit BLANK_LZ = 1'b1
)
(
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [31:0]           value_in,
    input  logic                  enable,
    output logic [DIGITS*7-1:0]   segs,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  ovf,
    output logic                  busy
);

    localparam int WORK_W = DIGITS * 4;
    localparam int SEG_W  = DIGITS * 7;
    localparam int CNT_W  = $clog2(IN_WIDTH + 1);

    function automatic logic [SEG_W-1:0] f_reset_segs();
        logic [SEG_W-1:0] s;
        for (int k = 0; k < DIGITS; k++) begin
            s[7*k +: 7] = ((k == 0) || !BLANK_LZ) ? SEG_ZERO : SEG_BLANK;
        end
        return s;
    endfunction

    localparam logic [SEG_W-1:0] SEGS_RST = f_reset_segs();

    state_e              state_q,    state_d;
    logic [IN_WIDTH-1:0] last_val_q, last_val_d;
    logic [IN_WIDTH-1:0] shift_q,    shift_d;
    logic [WORK_W-1:0]   work_q,     work_d;
    logic                ovf_work_q, ovf_work_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [WORK_W-1:0]   bcd_q,      bcd_d;
    logic                ovf_q,      ovf_d;
    logic [SEG_W-1:0]    segs_q,     segs_d;
    logic                busy_q,     busy_d;

    logic [WORK_W-1:0]   w_adj;
    logic [SEG_W-1:0]    w_dec;
    logic [SEG_W-1:0]    w_disp;
    logic                w_unused;

    assign w_unused = ^value_in;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_dec
            sc_bcd7seg u_dec (
                .i_bcd (work_q[4*k +: 4]),
                .o_seg (w_dec[7*k +: 7])
            );
        end
    endgenerate

    always_comb begin
        w_adj = work_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (work_q[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // Overflow dashes win over blanking; blanking scans from the top digit down.
    always_comb begin
        logic lead_zero;
        lead_zero = 1'b1;
        w_disp    = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (work_q[4*d +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
            if (ovf_work_q) begin
                w_disp[7*d +: 7] = SEG_DASH;
            end else if (BLANK_LZ && lead_zero && (d != 0)) begin
                w_disp[7*d +: 7] = SEG_BLANK;
            end else begin
                w_disp[7*d +: 7] = w_dec[7*d +: 7];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_val_d = last_val_q;
        shift_d    = shift_q;
        work_d     = work_q;
        ovf_work_d = ovf_work_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        segs_d     = segs_q;
        busy_d     = busy_q;
        unique case (state_q)
            IDLE: begin
                if (enable && (value_in[IN_WIDTH-1:0] != last_val_q)) begin
                    last_val_d = value_in[IN_WIDTH-1:0];
                    shift_d    = value_in[IN_WIDTH-1:0];
                    work_d     = '0;
                    ovf_work_d = 1'b0;
                    cnt_d      = CNT_W'(IN_WIDTH);
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                work_d     = {w_adj[WORK_W-2:0], shift_q[IN_WIDTH-1]};
                shift_d    = {shift_q[IN_WIDTH-2:0], 1'b0};
                ovf_work_d = ovf_work_q | w_adj[WORK_W-1];
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                bcd_d   = work_q;
                ovf_d   = ovf_work_q;
                segs_d  = w_disp;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            last_val_q <= '0;
            shift_q    <= '0;
            work_q     <= '0;
            ovf_work_q <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            segs_q     <= SEGS_RST;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_val_q <= last_val_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            ovf_work_q <= ovf_work_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            segs_q     <= segs_d;
            busy_q     <= busy_d;
        end
    end

    assign segs = segs_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_out_port_hex_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_out_port_hex_display
//  Description : Scoreboard bench driving three display configurations in
//                lockstep against a decimal reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_out_port_hex_display;

    localparam int W = 16;

    logic        clock    = 1'b0;
    logic        resetn   = 1'b0;
    logic        enable   = 1'b0;
    logic [31:0] value_in = '0;

    logic [34:0] segs_a, segs_b;
    logic [27:0] segs_c;
    logic [19:0] bcd_a, bcd_b;
    logic [15:0] bcd_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        busy_a, busy_b, busy_c;

    always #5 clock = ~clock;

    sc_out_port_hex_display #(.IN_WIDTH(W), .DIGITS(5), .BLANK_LZ(1'b1)) u_dut_a (
        .clock(clock), .resetn(resetn), .value_in(value_in), .enable(enable),
        .segs(segs_a), .bcd(bcd_a), .ovf(ovf_a), .busy(busy_a));

    sc_out_port_hex_display #(.IN_WIDTH(W), .DIGITS(5), .BLANK_LZ(1'b0)) u_dut_b (
        .clock(clock), .resetn(resetn), .value_in(value_in), .enable(enable),
        .segs(segs_b), .bcd(bcd_b), .ovf(ovf_b), .busy(busy_b));

    sc_out_port_hex_display #(.IN_WIDTH(W), .DIGITS(4), .BLANK_LZ(1'b1)) u_dut_c (
        .clock(clock), .resetn(resetn), .value_in(value_in), .enable(enable),
        .segs(segs_c), .bcd(bcd_c), .ovf(ovf_c), .busy(busy_c));

    typedef struct {
        logic [31:0] v;
        logic [34:0] sa, sb, sc;
        logic [19:0] ba, bb, bc;
        logic        oa, ob, oc;
    } exp_t;

    exp_t        scb[$];
    int          total = 0;
    int          bad   = 0;
    int          m_left = 0;
    logic [W-1:0] m_last = '0;

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic void calc(input longint v, input int nd, input bit blank,
                                 output logic [19:0] b, output logic [34:0] s,
                                 output logic o);
        longint lim = 1;
        longint t   = v;
        int     dig [10];
        int     hi  = 0;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        o = (v >= lim);
        b = '0;
        s = '1;
        for (int i = 0; i < nd; i++) begin
            dig[i] = int'(t % 10);
            t      = t / 10;
            b[4*i +: 4] = 4'(dig[i]);
            if (dig[i] != 0) hi = i;
        end
        for (int i = 0; i < nd; i++) begin
            if (o)                    s[7*i +: 7] = 7'b0111111;
            else if (blank && i > hi) s[7*i +: 7] = 7'b1111111;
            else                      s[7*i +: 7] = seg7(dig[i]);
        end
    endfunction

    function automatic exp_t make_exp(input longint v);
        exp_t e;
        e.v = 32'(v);
        calc(v, 5, 1'b1, e.ba, e.sa, e.oa);
        calc(v, 5, 1'b0, e.bb, e.sb, e.ob);
        calc(v, 4, 1'b1, e.bc, e.sc, e.oc);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a conversion occupies IN_WIDTH+1 busy cycles, then at least one idle cycle.
    always @(posedge clock) begin
        if (!resetn) begin
            m_left = 0;
            m_last = '0;
            scb.delete();
        end else if (m_left > 0) begin
            m_left--;
        end else if (enable && (value_in[W-1:0] != m_last)) begin
            m_last = value_in[W-1:0];
            m_left = W + 1;
            scb.push_back(make_exp(longint'(value_in[W-1:0])));
        end
    end

    logic prev_busy = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        if (!resetn) begin
            prev_busy = 1'b0;
        end else begin
            chk("busy_a", 64'(busy_a), 64'(m_left > 0));
            chk("busy_b", 64'(busy_b), 64'(m_left > 0));
            chk("busy_c", 64'(busy_c), 64'(m_left > 0));
            if (prev_busy && !busy_a) begin
                if (scb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL commit: got unexpected commit bcd_a=%h expected none", bcd_a);
                end else begin
                    e = scb.pop_front();
                    chk($sformatf("bcd_a(%0d)", e.v),  64'(bcd_a),  64'(e.ba));
                    chk($sformatf("segs_a(%0d)", e.v), 64'(segs_a), 64'(e.sa));
                    chk($sformatf("ovf_a(%0d)", e.v),  64'(ovf_a),  64'(e.oa));
                    chk($sformatf("bcd_b(%0d)", e.v),  64'(bcd_b),  64'(e.bb));
                    chk($sformatf("segs_b(%0d)", e.v), 64'(segs_b), 64'(e.sb));
                    chk($sformatf("ovf_b(%0d)", e.v),  64'(ovf_b),  64'(e.ob));
                    chk($sformatf("bcd_c(%0d)", e.v),  64'(bcd_c),  64'(e.bc[15:0]));
                    chk($sformatf("segs_c(%0d)", e.v), 64'(segs_c), 64'(e.sc[27:0]));
                    chk($sformatf("ovf_c(%0d)", e.v),  64'(ovf_c),  64'(e.oc));
                end
            end
            prev_busy = busy_a;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_reset();
        exp_t e;
        e = make_exp(0);
        chk("rst_busy",   64'({busy_a, busy_b, busy_c}), 64'(0));
        chk("rst_ovf",    64'({ovf_a, ovf_b, ovf_c}),    64'(0));
        chk("rst_bcd_a",  64'(bcd_a),  64'(0));
        chk("rst_bcd_c",  64'(bcd_c),  64'(0));
        chk("rst_segs_a", 64'(segs_a), 64'(e.sa));
        chk("rst_segs_b", 64'(segs_b), 64'(e.sb));
        chk("rst_segs_c", 64'(segs_c), 64'(e.sc[27:0]));
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((m_left != 0 || scb.size() != 0 ||
                (enable && value_in[W-1:0] != m_last)) && t < 300) begin
            step(1);
            t++;
        end
        if (t >= 300) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got still busy after %0d cycles expected idle", t);
        end
    endtask

    initial begin
        step(3);
        check_reset();
        resetn = 1'b1;
        step(2);

        enable = 1'b1;
        value_in = 32'h0000_3039;          wait_idle();
        value_in = 32'd7;                  wait_idle();

        value_in = 32'd100;                step(5);
        value_in = 32'd65535;              wait_idle();

        value_in = 32'd10000;              wait_idle();
        value_in = 32'd9999;               wait_idle();

        enable = 1'b0; value_in = 32'd42;  step(30);
        enable = 1'b1;                     wait_idle();

        value_in = 32'hFFFF_0005;          wait_idle();
        value_in = 32'hABCD_0005;          step(25);

        value_in = 32'd54321;              step(6);
        resetn = 1'b0;
        #2;
        check_reset();
        step(3);
        resetn = 1'b1;
        wait_idle();

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       value_in = $urandom_range(0, 9);
                1:       value_in = $urandom_range(0, 20000);
                2:       value_in = $urandom();
                default: value_in = value_in;
            endcase
            enable = ($urandom_range(0, 5) != 0);
            step($urandom_range(1, 25));
        end
        enable = 1'b1;
        wait_idle();
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
